// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship front-end and core.
package battleship_pkg;

  localparam int unsigned DEB_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_e;

endpackage

// File: rtl/btn_conditioner.sv
// One button: two-flop synchroniser, counter debounce and rising-edge detect.
module btn_conditioner
  import battleship_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  // Level follows the synced input only after DEB_CYCLES consecutive differing cycles.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Board-button front end for the battleship core: conditioned start pulse,
// arbitrated player A/B press pulses and X/Y coordinates latched on acceptance.
module player_input_ctrl
  import battleship_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_raw,
  input  logic       pA_raw,
  input  logic       pB_raw,
  input  logic [1:0] X_sw,
  input  logic [1:0] Y_sw,
  input  logic       lock,
  output logic       start,
  output logic       pAb,
  output logic       pBb,
  output logic [1:0] X,
  output logic [1:0] Y,
  output logic       busy,
  output logic       conflict
);

  logic start_level, start_rise;
  logic a_level, a_rise;
  logic b_level, b_rise;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_start (
    .clk(clk), .rst(rst), .raw(start_raw), .level(start_level), .rise(start_rise)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_btn_a (
    .clk(clk), .rst(rst), .raw(pA_raw), .level(a_level), .rise(a_rise)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_btn_b (
    .clk(clk), .rst(rst), .raw(pB_raw), .level(b_level), .rise(b_rise)
  );

  logic [1:0] x_sync1_q, x_sync2_q, y_sync1_q, y_sync2_q;
  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic       pa_q, pa_d;
  logic       pb_q, pb_d;
  logic       busy_q, busy_d;
  logic       conflict_q, conflict_d;
  logic [1:0] x_q, x_d, y_q, y_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_sync1_q  <= 2'd0;
      x_sync2_q  <= 2'd0;
      y_sync1_q  <= 2'd0;
      y_sync2_q  <= 2'd0;
      state_q    <= IDLE;
      start_q    <= 1'b0;
      pa_q       <= 1'b0;
      pb_q       <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      x_q        <= 2'd0;
      y_q        <= 2'd0;
    end else begin
      x_sync1_q  <= X_sw;
      x_sync2_q  <= x_sync1_q;
      y_sync1_q  <= Y_sw;
      y_sync2_q  <= y_sync1_q;
      state_q    <= state_d;
      start_q    <= start_d;
      pa_q       <= pa_d;
      pb_q       <= pb_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  // Arbitration: only IDLE accepts a press; A wins a tie and B is dropped.
  always_comb begin
    state_d    = state_q;
    start_d    = start_rise & start_level;
    pa_d       = 1'b0;
    pb_d       = 1'b0;
    conflict_d = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    case (state_q)
      IDLE: begin
        if (!lock) begin
          if (a_rise) begin
            pa_d       = 1'b1;
            conflict_d = b_rise;
            x_d        = x_sync2_q;
            y_d        = y_sync2_q;
            state_d    = HOLD_A;
          end else if (b_rise) begin
            pb_d    = 1'b1;
            x_d     = x_sync2_q;
            y_d     = y_sync2_q;
            state_d = HOLD_B;
          end
        end
      end
      HOLD_A:  if (!a_level) state_d = IDLE;
      HOLD_B:  if (!b_level) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign start    = start_q;
  assign pAb      = pa_q;
  assign pBb      = pb_q;
  assign X        = x_q;
  assign Y        = y_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed and randomized bench for player_input_ctrl with a window-based reference model.
module tb_player_input_ctrl;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic       start_raw, pA_raw, pB_raw, lock;
  logic [1:0] X_sw, Y_sw;
  logic       start, pAb, pBb, busy, conflict;
  logic [1:0] X, Y;

  player_input_ctrl #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_raw(start_raw), .pA_raw(pA_raw), .pB_raw(pB_raw),
    .X_sw(X_sw), .Y_sw(Y_sw), .lock(lock), .start(start), .pAb(pAb), .pBb(pBb),
    .X(X), .Y(Y), .busy(busy), .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: raw-sample history per input, debounced levels, holder id.
  logic [15:0] ha, hb, hs;
  logic [7:0]  xh, yh;
  logic        la_c, la_p, lb_c, lb_p, ls_c, ls_p;
  int          holder;
  logic [1:0]  ex, ey;
  logic        e_start, e_pa, e_pb, e_cf, e_busy;

  // Observed pulse tallies for directed windows.
  int n_pa, n_pb, n_st, n_cf, n_busy;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ha = '0; hb = '0; hs = '0; xh = '0; yh = '0;
    la_c = 0; la_p = 0; lb_c = 0; lb_p = 0; ls_c = 0; ls_p = 0;
    holder = 0; ex = 0; ey = 0;
    e_start = 0; e_pa = 0; e_pb = 0; e_cf = 0; e_busy = 0;
  endtask

  // Level becomes v once the last DEB synced samples (raw delayed by two edges) all equal v.
  function automatic logic deb(input logic [15:0] h, input logic cur);
    logic v;
    v = h[2];
    for (int i = 2; i <= DEB + 1; i++) if (h[i] != v) return cur;
    return v;
  endfunction

  task automatic clr_cnt();
    n_pa = 0; n_pb = 0; n_st = 0; n_cf = 0; n_busy = 0;
  endtask

  task automatic step();
    logic c_rst, c_a, c_b, c_s, c_lock, ra, rb, rs;
    logic [1:0] c_x, c_y;
    c_rst = rst; c_a = pA_raw; c_b = pB_raw; c_s = start_raw; c_lock = lock;
    c_x = X_sw; c_y = Y_sw;
    @(posedge clk);
    #1;
    if (!c_rst) begin
      model_clear();
    end else begin
      ha = {ha[14:0], c_a}; hb = {hb[14:0], c_b}; hs = {hs[14:0], c_s};
      xh = {xh[5:0], c_x};  yh = {yh[5:0], c_y};
      ra = la_c & ~la_p; rb = lb_c & ~lb_p; rs = ls_c & ~ls_p;
      e_start = rs; e_pa = 0; e_pb = 0; e_cf = 0;
      if (holder == 0) begin
        if (!c_lock) begin
          if (ra) begin
            e_pa = 1; e_cf = rb; holder = 1; ex = xh[5:4]; ey = yh[5:4];
          end else if (rb) begin
            e_pb = 1; holder = 2; ex = xh[5:4]; ey = yh[5:4];
          end
        end
      end else if (holder == 1) begin
        if (!la_c) holder = 0;
      end else if (!lb_c) begin
        holder = 0;
      end
      e_busy = (holder != 0);
      la_p = la_c; la_c = deb(ha, la_c);
      lb_p = lb_c; lb_c = deb(hb, lb_c);
      ls_p = ls_c; ls_c = deb(hs, ls_c);
    end
    chk("start", 2'(start), 2'(e_start));
    chk("pAb", 2'(pAb), 2'(e_pa));
    chk("pBb", 2'(pBb), 2'(e_pb));
    chk("conflict", 2'(conflict), 2'(e_cf));
    chk("busy", 2'(busy), 2'(e_busy));
    chk("X", X, ex);
    chk("Y", Y, ey);
    n_pa += int'(pAb); n_pb += int'(pBb); n_st += int'(start);
    n_cf += int'(conflict); n_busy += int'(busy);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int lat;
    rst = 0; start_raw = 0; pA_raw = 0; pB_raw = 0; lock = 0; X_sw = 0; Y_sw = 0;
    model_clear();
    clr_cnt();
    #12;
    chk("rst_start", 2'(start), 2'd0);
    chk("rst_pAb", 2'(pAb), 2'd0);
    chk("rst_busy", 2'(busy), 2'd0);
    chk("rst_X", X, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    idle(3);

    // Single A press with X=1,Y=0: latency and release latency.
    pA_raw = 1; X_sw = 2'd1; Y_sw = 2'd0; clr_cnt(); lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (pAb && lat == 0) lat = i;
    end
    chk("t1_pa_latency", 2'(lat == 7), 2'd1);
    pA_raw = 0; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (!busy && lat == 0) lat = i;
    end
    chk("t1_busy_fall_latency", 2'(lat == 7), 2'd1);
    chk("t1_pa_count", 2'(n_pa), 2'd1);
    chk("t1_X", X, 2'd1);
    chk("t1_Y", Y, 2'd0);

    // Short B glitch is filtered; a DEB-long press is accepted.
    clr_cnt(); pB_raw = 1; idle(DEB - 1); pB_raw = 0; idle(10);
    chk("t2_glitch_pb", 2'(n_pb), 2'd0);
    chk("t2_glitch_busy", 2'(n_busy != 0), 2'd0);
    clr_cnt(); pB_raw = 1; idle(DEB); pB_raw = 0; idle(12);
    chk("t2_clean_pb", 2'(n_pb), 2'd1);

    // Simultaneous A and B rise.
    X_sw = 2'd2; Y_sw = 2'd3; clr_cnt(); pA_raw = 1; pB_raw = 1; idle(10);
    pA_raw = 0; pB_raw = 0; idle(12);
    chk("t3_pa", 2'(n_pa), 2'd1);
    chk("t3_cf", 2'(n_cf), 2'd1);
    chk("t3_pb", 2'(n_pb), 2'd0);
    chk("t3_X", X, 2'd2);
    chk("t3_Y", Y, 2'd3);

    // B during an A hold is ignored; a fresh B afterwards is accepted.
    clr_cnt(); pA_raw = 1; idle(8); pB_raw = 1; idle(10); pB_raw = 0; idle(8);
    pA_raw = 0; idle(10);
    chk("t4_pb_in_hold", 2'(n_pb), 2'd0);
    clr_cnt(); pB_raw = 1; idle(8); pB_raw = 0; idle(10);
    chk("t4_pb_after", 2'(n_pb), 2'd1);

    // Lock suppresses presses; a button held across unlock needs a fresh rise.
    lock = 1; X_sw = 2'd0; Y_sw = 2'd1; clr_cnt(); pA_raw = 1; idle(10);
    chk("t5_locked_pa", 2'(n_pa), 2'd0);
    chk("t5_locked_X", X, 2'd2);
    chk("t5_locked_Y", Y, 2'd3);
    lock = 0; idle(10);
    chk("t5_unlock_held_pa", 2'(n_pa), 2'd0);
    pA_raw = 0; idle(10); pA_raw = 1; idle(10); pA_raw = 0; idle(10);
    chk("t5_fresh_pa", 2'(n_pa), 2'd1);
    chk("t5_X", X, 2'd0);
    chk("t5_Y", Y, 2'd1);

    // Asynchronous reset in the middle of an A hold.
    pA_raw = 1; idle(9);
    #2 rst = 0;
    #1;
    chk("t6_rst_busy", 2'(busy), 2'd0);
    chk("t6_rst_pAb", 2'(pAb), 2'd0);
    chk("t6_rst_X", X, 2'd0);
    chk("t6_rst_Y", Y, 2'd0);
    chk("t6_rst_conflict", 2'(conflict), 2'd0);
    model_clear();
    pA_raw = 0;
    idle(3);
    rst = 1;
    idle(3);
    clr_cnt(); start_raw = 1; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (start && lat == 0) lat = i;
    end
    start_raw = 0; idle(10);
    chk("t6_start_latency", 2'(lat == 7), 2'd1);
    chk("t6_start_count", 2'(n_st), 2'd1);
    chk("t6_busy_after_rst", 2'(n_busy != 0), 2'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5) == 0) pA_raw = ~pA_raw;
      if ($urandom_range(5) == 0) pB_raw = ~pB_raw;
      if ($urandom_range(7) == 0) start_raw = ~start_raw;
      if ($urandom_range(3) == 0) X_sw = 2'($urandom);
      if ($urandom_range(3) == 0) Y_sw = 2'($urandom);
      if ($urandom_range(39) == 0) lock = ~lock;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_input_ctrl.md
Name: player_input_ctrl

Overview:
- Front-end conditioner for the battleship game core. It drives the core's button interface: start, pAb, pBb, X and Y.
- Inputs are raw board buttons and switches. Each button is synchronised and debounced, then converted to a single-cycle press pulse.
- X/Y are latched at the moment a press is accepted. A and B presses are arbitrated so the core never sees overlapping player pulses.
- Sits between board I/O and the battleship core, on the side of that interface opposite the game logic.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required before a debounced level changes (minimum 1).
- CNT_W, 16: debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_raw  input  1  raw start button, asynchronous.
- pA_raw  input  1  raw player A button, asynchronous.
- pB_raw  input  1  raw player B button, asynchronous.
- X_sw  input  2  raw column switches, asynchronous.
- Y_sw  input  2  raw row switches, asynchronous.
- lock  input  1  from core: 1 = ignore player presses (e.g. game over).
- start  output  1  one-cycle start pulse.
- pAb  output  1  one-cycle player A press pulse.
- pBb  output  1  one-cycle player B press pulse.
- X  output  2  column latched at last accepted player press.
- Y  output  2  row latched at last accepted player press.
- busy  output  1  1 while an accepted player button has not yet been released.
- conflict  output  1  one-cycle pulse: A and B rose on the same cycle.

Behaviour:
- Reset (rst=0, async): every output is 0; sync flops, debounced levels and counters are 0; FSM is in IDLE. Deassertion is taken synchronously by the first clk edge after rst rises.
- Synchroniser: two-flop chain on each of start_raw, pA_raw, pB_raw, X_sw and Y_sw.
- Debounce, per button:
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments each cycle.
  - When the counter reaches DEB_CYCLES-1 while the levels still differ, the debounced level takes the synced value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles is never seen downstream.
- Rise detect: rise = debounced & ~debounced_q. All outputs are registered.
- Latency: raw 0->1 held steady produces the output pulse exactly 2 + DEB_CYCLES + 1 edges later (7 cycles at default). Every pulse is exactly 1 cycle wide.
- start: pulses on each start rise, independent of the FSM and of lock.
- FSM states: IDLE, HOLD_A, HOLD_B.
  - IDLE, lock=0, rise_A: pAb=1 for 1 cycle; X/Y <= synced X_sw/Y_sw; go to HOLD_A.
  - IDLE, lock=0, rise_B only: pBb=1; latch X/Y; go to HOLD_B.
  - IDLE, rise_A and rise_B on the same cycle: A wins (as above); conflict=1 for 1 cycle; B is dropped and not queued.
  - IDLE, lock=1: rises are ignored; no pulse; X/Y unchanged; stay in IDLE.
  - HOLD_A: every B rise is ignored. When debounced A falls to 0, return to IDLE on that edge.
  - HOLD_B: symmetric to HOLD_A.
  - busy = 1 in HOLD_A and HOLD_B.
- X/Y hold their value between accepted presses. Switch changes while not accepting a press have no effect on X/Y.
- A button already held high when lock falls does not pulse; a fresh rise is required.
- The 2-bit X/Y values need no range checking.

Decomposition:
- Shared package battleship_pkg:
  - FSM state encoding: IDLE=2'd0, HOLD_A=2'd1, HOLD_B=2'd2.
  - Default DEB_CYCLES constant.
- Sub-module btn_conditioner(clk, rst, raw, level, rise):
  - Contains the sync, debounce and rise-detect logic.
  - Instantiated three times (start, A, B), parameterised by DEB_CYCLES.
- X/Y synchronisers and the FSM live in the top module.

Test Plan:
- Reset, then pA_raw=1 for 10 cycles with X_sw=1, Y_sw=0:
  - pAb high for exactly 1 cycle, 7 edges after the raw rise.
  - X=1, Y=0 held afterwards.
  - busy falls 7 edges after the raw fall.
- pB_raw glitch of 3 cycles (DEB_CYCLES=4) -> no pBb, busy stays 0. A clean 4-cycle press -> exactly one pBb pulse.
- pA_raw and pB_raw rise on the same cycle with X_sw=2, Y_sw=3 -> one pAb pulse and one conflict pulse, no pBb, X=2, Y=3.
- Hold A, press B for 10 cycles inside the hold, release A, then press B again -> the first B is ignored; the second B gives one pBb pulse.
- lock=1, press A -> no pulse, X/Y unchanged. Drop lock while A is still held -> no pulse. Release A and press again -> pulse.
- Assert rst=0 mid-HOLD_A on a non-clock edge -> all outputs are 0 immediately; after release, FSM is in IDLE. Press start -> one start pulse 7 edges later.
